// File: rtl/counter_seq_monitor_pkg.sv
// Shared constants and types for the counter sequence monitor.
// Counter limits, event codes and the event record layout.
package counter_seq_monitor_pkg;

  localparam logic [3:0] CNT1_MAX = 4'd11;
  localparam logic [3:0] CNT2_MAX = 4'd14;
  localparam int EVT_DEPTH = 4;
  localparam int EVT_W = 10;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_WRAP1 = 2'b01,
    EVT_FRAME = 2'b10,
    EVT_ERR   = 2'b11
  } evt_type_e;

  typedef struct packed {
    evt_type_e  kind;
    logic [3:0] c2;
    logic [3:0] c1;
  } evt_t;

  // Modular increment of a counter that wraps after max.
  function automatic logic [3:0] inc_mod(
    input logic [3:0] v,
    input logic [3:0] max
  );
    return (v == max) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/counter_seq_monitor_fifo.sv
// Event queue: small in-order FIFO with head shown from storage.
// A push into a full queue is kept only when a pop frees a slot.
module evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic do_pop;
  logic do_push;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake qualification: pops need data, pushes need room.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
  end

  // Storage write; contents need no reset as head is qualified.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Status and head view.
  always_comb begin
    full  = (count == FULL_CNT);
    empty = (count == '0);
    dout  = mem[rd_ptr];
  end

endmodule

// File: rtl/counter_seq_monitor.sv
// Checks a mod-12 / mod-15 counter pair for sequence breaks and
// queues WRAP1, FRAME and ERR events for a downstream consumer.
module counter_seq_monitor
  import counter_seq_monitor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cnt1,
  input  logic [3:0]       cnt2,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [EVT_W-1:0] evt_data,
  output logic [7:0]       frame_cnt,
  output logic             err,
  output logic             overflow,
  output logic             fifo_full
);

  logic [3:0] prev1;
  logic [3:0] prev2;
  logic primed;
  logic [3:0] exp1;
  logic [3:0] exp2;
  logic wrap1;
  logic frame;
  logic mismatch;
  logic is_err;
  logic is_frame;
  logic is_wrap;
  evt_type_e kind;
  evt_t ev;
  logic push;
  logic empty;
  logic full;
  logic drop;
  logic [EVT_W-1:0] head;

  // Previous sample capture; the first edge after reset only primes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev1  <= '0;
      prev2  <= '0;
      primed <= 1'b0;
    end else begin
      prev1  <= cnt1;
      prev2  <= cnt2;
      primed <= 1'b1;
    end
  end

  // Expected successor of the previous sample and the checks on it.
  always_comb begin
    wrap1    = (prev1 == CNT1_MAX);
    frame    = wrap1 && (prev2 == CNT2_MAX);
    exp1     = inc_mod(prev1, CNT1_MAX);
    exp2     = wrap1 ? inc_mod(prev2, CNT2_MAX) : prev2;
    mismatch = (cnt1 != exp1) || (cnt2 != exp2);
    is_err   = primed && mismatch;
    is_frame = primed && !mismatch && frame;
    is_wrap  = primed && !mismatch && wrap1 && !frame;
  end

  // One event per cycle, ERR over FRAME over WRAP1.
  always_comb begin
    kind = EVT_NONE;
    unique case (1'b1)
      is_err:   kind = EVT_ERR;
      is_frame: kind = EVT_FRAME;
      is_wrap:  kind = EVT_WRAP1;
      default:  kind = EVT_NONE;
    endcase
    push = (kind != EVT_NONE);
    ev   = '{kind: kind, c2: cnt2, c1: cnt1};
  end

  evt_fifo #(
    .W     (EVT_W),
    .DEPTH (EVT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (ev),
    .pop   (evt_ready),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .drop  (drop)
  );

  // Sticky flags and the frame counter, which counts dropped frames too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (is_err) err <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (is_frame) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Downstream view; data reads zero whenever nothing is queued.
  always_comb begin
    evt_valid = !empty;
    evt_data  = evt_valid ? head : '0;
    fifo_full = full;
  end

endmodule

// File: tb/tb_counter_seq_monitor.sv
// Scoreboard bench for counter_seq_monitor.
// Reference treats the counter pair as one position 0..179.
module tb_counter_seq_monitor;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] cnt1;
  logic [3:0] cnt2;
  logic evt_ready;
  logic evt_valid;
  logic [9:0] evt_data;
  logic [7:0] frame_cnt;
  logic err;
  logic overflow;
  logic fifo_full;

  counter_seq_monitor dut (
    .clk       (clk),
    .rst       (rst),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .frame_cnt (frame_cnt),
    .err       (err),
    .overflow  (overflow),
    .fifo_full (fifo_full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [9:0] exp_q[$];
  bit m_primed;
  int m_prev;
  bit m_err;
  bit m_ovf;
  logic [7:0] m_frame;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  // Reference model: events come from position arithmetic.
  initial begin
    int cur;
    logic [1:0] ty;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        m_primed = 0;
        m_prev = 0;
        m_err = 0;
        m_ovf = 0;
        m_frame = 8'd0;
      end else begin
        cur = int'(cnt2) * 12 + int'(cnt1);
        if (m_primed) begin
          ty = 2'b00;
          if (cur != (m_prev + 1) % 180) begin
            ty = 2'b11;
            m_err = 1;
          end else if (m_prev == 179) begin
            ty = 2'b10;
            m_frame = m_frame + 8'd1;
          end else if (m_prev % 12 == 11) begin
            ty = 2'b01;
          end
          if (ty != 2'b00) begin
            if (exp_q.size() < 4) exp_q.push_back({ty, cnt2, cnt1});
            else m_ovf = 1;
          end
        end
        m_primed = 1;
        m_prev = cur;
      end
    end
  end

  // Monitor: compare the presented head, then retire it on handshake.
  initial begin
    forever begin
      @(negedge clk);
      chk("evt_valid", evt_valid, exp_q.size() > 0);
      chk("evt_data", evt_data, exp_q.size() > 0 ? exp_q[0] : 10'h0);
      chk("fifo_full", fifo_full, exp_q.size() == 4);
      chk("err", err, m_err);
      chk("overflow", overflow, m_ovf);
      chk("frame_cnt", frame_cnt, m_frame);
      if (!rst && evt_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  task automatic drive(input int p, input bit rdy);
    @(posedge clk);
    #2;
    cnt1 = 4'(p % 12);
    cnt2 = 4'(p / 12);
    evt_ready = rdy;
  endtask

  task automatic do_reset(input int p);
    @(posedge clk);
    #2;
    rst = 1'b1;
    evt_ready = 1'b0;
    cnt1 = 4'(p % 12);
    cnt2 = 4'(p / 12);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int p;
    rst = 1'b1;
    cnt1 = 4'd0;
    cnt2 = 4'd0;
    evt_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    for (int i = 1; i <= 12; i++) drive(i, 1'b1);
    drive(13, 1'b1);
    @(negedge clk);
    chk("wrap1_data", evt_data, 10'h110);
    chk("wrap1_err", err, 1'b0);

    for (int i = 14; i <= 179; i++) drive(i, 1'b1);
    drive(0, 1'b1);
    drive(1, 1'b1);
    @(negedge clk);
    chk("frame_data", evt_data, 10'h200);
    chk("frame_cnt1", frame_cnt, 8'd1);

    drive(2, 1'b1);
    drive(3, 1'b1);
    drive(5, 1'b1);
    drive(6, 1'b1);
    @(negedge clk);
    chk("err_data", evt_data, 10'h305);
    chk("err_set", err, 1'b1);
    drive(7, 1'b1);
    @(negedge clk);
    chk("after_err_quiet", evt_valid, 1'b0);
    chk("err_sticky", err, 1'b1);

    for (int i = 8; i <= 61; i++) drive(i, 1'b0);
    @(negedge clk);
    chk("ovf_full", fifo_full, 1'b1);
    chk("ovf_flag", overflow, 1'b1);
    for (int i = 62; i <= 70; i++) drive(i, 1'b1);

    do_reset(0);
    for (int i = 1; i <= 59; i++) drive(i, 1'b0);
    drive(60, 1'b1);
    drive(61, 1'b0);
    @(negedge clk);
    chk("simul_full", fifo_full, 1'b1);
    chk("simul_no_ovf", overflow, 1'b0);
    for (int i = 62; i <= 70; i++) drive(i, 1'b1);

    do_reset(0);
    for (int i = 1; i <= 12; i++) drive(i, 1'b0);
    for (int i = 30; i <= 37; i++) drive(i, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_data", evt_data, 10'h0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_frame", frame_cnt, 8'd0);
    cnt1 = 4'd5;
    cnt2 = 4'd7;
    @(posedge clk);
    #2;
    rst = 1'b0;
    drive(90, 1'b1);
    @(negedge clk);
    chk("reprime_quiet", evt_valid, 1'b0);

    for (int i = 0; i < 258; i++) begin
      drive(178, 1'b1);
      drive(179, 1'b1);
      drive(0, 1'b1);
    end
    drive(1, 1'b1);
    @(negedge clk);
    chk("frame_wrap", frame_cnt, 8'd2);

    p = 1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom % 16 == 0) p = $urandom % 180;
      else p = (p + 1) % 180;
      drive(p, 1'($urandom % 2));
    end
    for (int i = 0; i < 6; i++) begin
      p = (p + 1) % 180;
      drive(p, 1'b1);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
